lane_dualportram_ne: RTL

Multi-lane simple dual-port message RAM for the LDPC decoder's check/variable-node message storage. It provides LANES independent banks, each Z words of W bits with one write port and one read port. Each lane has a single-edge registered read with selectable idle-output mode and optional write-to-read bypass. A built-in clear sequencer zeroes all banks after reset or on request, so the decoder can start a new codeword without re-loading stale messages.

---
 rtl/lane_dualportram_ne.sv | 114 +++++++++++
 1 files changed

// File: rtl/lane_dualportram_ne.sv
// Multi-lane simple dual-port message RAM with per-lane registered read,
// out-of-range flagging and a clear sequencer that zeroes every bank.
module lane_dualportram_ne #(
    parameter int Z            = 511,
    parameter int W            = 6,
    parameter int COLADDR_BITS = 9,
    parameter int LANES        = 2,
    parameter int HOLD_MODE    = 0,
    parameter int BYPASS       = 1
) (
    input  logic                            memclk,
    input  logic                            rst,
    input  logic                            init,
    output logic                            busy,
    input  logic [LANES*COLADDR_BITS-1:0]   WA,
    input  logic [LANES-1:0]                wr_in,
    input  logic [LANES*W-1:0]              DIN,
    input  logic [LANES*COLADDR_BITS-1:0]   RA,
    input  logic [LANES-1:0]                rd_in,
    output logic [LANES*W-1:0]              DOUT,
    output logic [LANES-1:0]                rd_valid,
    output logic [LANES-1:0]                oor_err
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [COLADDR_BITS-1:0] LAST = COLADDR_BITS'(Z - 1);

    state_t                  state, state_nxt;
    logic [COLADDR_BITS-1:0] clr_addr, clr_addr_nxt;
    logic                    run;
    logic                    restart;

    always_ff @(posedge memclk or negedge rst) begin
        if (!rst) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = '0;
        case (state)
            S_CLEAR: begin
                if (clr_addr == LAST) state_nxt = S_RUN;
                else                  clr_addr_nxt = clr_addr + 1'b1;
            end
            S_RUN: begin
                if (init) state_nxt = S_CLEAR;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign busy    = (state == S_CLEAR);
    assign run     = (state == S_RUN);
    assign restart = run && init;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0]            bank [Z];
        logic [COLADDR_BITS-1:0] wa, ra;
        logic [W-1:0]            din;
        logic [W-1:0]            dout_q;
        logic                    valid_q, oor_q;
        logic                    wr_ok, rd_ok, wr_bad, rd_bad;

        assign wa     = WA[g*COLADDR_BITS +: COLADDR_BITS];
        assign ra     = RA[g*COLADDR_BITS +: COLADDR_BITS];
        assign din    = DIN[g*W +: W];
        assign wr_ok  = run && wr_in[g] && (wa <= LAST);
        assign wr_bad = run && wr_in[g] && (wa >  LAST);
        assign rd_ok  = run && rd_in[g] && (ra <= LAST);
        assign rd_bad = run && rd_in[g] && (ra >  LAST);

        always_ff @(posedge memclk) begin
            if (!run)       bank[clr_addr] <= '0;
            else if (wr_ok) bank[wa]       <= din;
        end

        // Outputs are forced to 0 on the init edge too, so DOUT/rd_valid read 0 for the whole clear.
        always_ff @(posedge memclk or negedge rst) begin
            if (!rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
                oor_q   <= 1'b0;
            end else begin
                if (restart)              oor_q <= 1'b0;
                else if (wr_bad || rd_bad) oor_q <= 1'b1;

                if (!run || restart) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (rd_in[g]) begin
                    valid_q <= 1'b1;
                    if (!rd_ok)                                dout_q <= '0;
                    else if (BYPASS != 0 && wr_ok && wa == ra) dout_q <= din;
                    else                                       dout_q <= bank[ra];
                end else begin
                    valid_q <= 1'b0;
                    if (HOLD_MODE == 0) dout_q <= '0;
                end
            end
        end

        assign DOUT[g*W +: W] = dout_q;
        assign rd_valid[g]    = valid_q;
        assign oor_err[g]     = oor_q;
    end

endmodule
